// File: rtl/thresholding_cfg_pkg.sv
// thresholding_cfg_pkg: shared state and response types for the AXI-Lite configuration bridges
//   cfg_state_e : bridge FSM states (one configuration op in flight at a time)
//   RESP_OKAY   : the only AXI response these bridges ever return
package thresholding_cfg_pkg;
    typedef enum logic [2:0] {IDLE, WR_ISSUE, WR_RESP, RD_ISSUE, RD_WAIT, RD_RESP} cfg_state_e;
    localparam logic [1:0] RESP_OKAY = 2'b00;
endpackage

// File: rtl/thresholding_axilite_cfg.sv
// thresholding_axilite_cfg: AXI4-Lite slave driving the thresholding core's configuration port
//   clk, rst                       clock, synchronous active-high reset
//   s_aw*/s_w*/s_b*                AXI-Lite write address, data and response channels
//   s_ar*/s_r*                     AXI-Lite read address and data channels
//   cfg_en, cfg_we, cfg_a, cfg_d   one-cycle configuration op towards the core
//   cfg_rack, cfg_q                readback return from the core
module thresholding_axilite_cfg
    import thresholding_cfg_pkg::*;
#(
    parameter int CFG_ADDR_BITS = 8,
    parameter int K             = 16,
    parameter bit SIGNED        = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_awvalid,
    output logic                     s_awready,
    input  logic [CFG_ADDR_BITS+1:0] s_awaddr,
    input  logic                     s_wvalid,
    output logic                     s_wready,
    input  logic [31:0]              s_wdata,
    input  logic [3:0]               s_wstrb,
    output logic                     s_bvalid,
    input  logic                     s_bready,
    output logic [1:0]               s_bresp,
    input  logic                     s_arvalid,
    output logic                     s_arready,
    input  logic [CFG_ADDR_BITS+1:0] s_araddr,
    output logic                     s_rvalid,
    input  logic                     s_rready,
    output logic [31:0]              s_rdata,
    output logic [1:0]               s_rresp,
    output logic                     cfg_en,
    output logic                     cfg_we,
    output logic [CFG_ADDR_BITS-1:0] cfg_a,
    output logic [K-1:0]             cfg_d,
    input  logic                     cfg_rack,
    input  logic [K-1:0]             cfg_q
);
    cfg_state_e state_q, state_d;
    logic wr_rdy_q, wr_rdy_d, rd_rdy_q, rd_rdy_d, rr_q, rr_d;
    logic [CFG_ADDR_BITS-1:0] addr_q, addr_d;
    logic [K-1:0] data_q, data_d;
    logic [31:0] rdata_q, rdata_d;
    logic wr_ok, rd_ok, hs_wr, hs_rd, offer, pick_wr, pick_rd, unused_ok;
    assign wr_ok = s_awvalid & s_wvalid;
    assign rd_ok = s_arvalid;
    assign hs_wr = wr_rdy_q & wr_ok;
    assign hs_rd = rd_rdy_q & rd_ok;
    // A new grant is offered only from IDLE while no ready pulse is already on the bus;
    // rr_q = 0 favours the write side when both sides are eligible.
    assign offer   = (state_q == IDLE) & ~wr_rdy_q & ~rd_rdy_q;
    assign pick_wr = offer & wr_ok & (~rd_ok | ~rr_q);
    assign pick_rd = offer & rd_ok & (~wr_ok | rr_q);
    assign unused_ok = ^{s_wstrb, s_awaddr[1:0], s_araddr[1:0], s_wdata};
    always_comb begin
        state_d  = state_q;
        wr_rdy_d = pick_wr;
        rd_rdy_d = pick_rd;
        rr_d     = rr_q;
        addr_d   = addr_q;
        data_d   = data_q;
        rdata_d  = rdata_q;
        case (state_q)
            IDLE: begin
                if (hs_wr) begin
                    state_d = WR_ISSUE;
                    addr_d  = s_awaddr[CFG_ADDR_BITS+1:2];
                    data_d  = s_wdata[K-1:0];
                    rr_d    = ~rr_q;
                end else if (hs_rd) begin
                    state_d = RD_ISSUE;
                    addr_d  = s_araddr[CFG_ADDR_BITS+1:2];
                    rr_d    = ~rr_q;
                end
            end
            WR_ISSUE: state_d = WR_RESP;
            WR_RESP:  state_d = s_bready ? IDLE : WR_RESP;
            RD_ISSUE: state_d = RD_WAIT;
            RD_WAIT: begin
                if (cfg_rack) begin
                    state_d = RD_RESP;
                    rdata_d = SIGNED ? 32'($signed(cfg_q)) : 32'(cfg_q);
                end
            end
            RD_RESP:  state_d = s_rready ? IDLE : RD_RESP;
            default:  state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            wr_rdy_q <= 1'b0;
            rd_rdy_q <= 1'b0;
            rr_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_rdy_q <= wr_rdy_d;
            rd_rdy_q <= rd_rdy_d;
            rr_q     <= rr_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            rdata_q  <= rdata_d;
        end
    end
    assign s_awready = wr_rdy_q;
    assign s_wready  = wr_rdy_q;
    assign s_arready = rd_rdy_q;
    assign s_bvalid  = state_q == WR_RESP;
    assign s_bresp   = RESP_OKAY;
    assign s_rvalid  = state_q == RD_RESP;
    assign s_rdata   = rdata_q;
    assign s_rresp   = RESP_OKAY;
    assign cfg_en    = (state_q == WR_ISSUE) | (state_q == RD_ISSUE);
    assign cfg_we    = state_q == WR_ISSUE;
    assign cfg_a     = addr_q;
    assign cfg_d     = data_q;
endmodule

// File: tb/tb_thresholding_axilite_cfg.sv
// tb_thresholding_axilite_cfg: directed bench for the AXI-Lite config bridge, signed and unsigned copies
module tb_thresholding_axilite_cfg;
    typedef struct packed {logic we; logic [7:0] a; logic [15:0] d;} op_t;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;
    logic s_awvalid = 0, s_wvalid = 0, s_bready = 1, s_arvalid = 0, s_rready = 1, cfg_rack = 0;
    logic [9:0] s_awaddr = 0, s_araddr = 0;
    logic [31:0] s_wdata = 0;
    logic [3:0] s_wstrb = 0;
    logic [15:0] cfg_q = 0;
    logic [1:0] awready, wready, bvalid, arready, rvalid, cfg_en, cfg_we;
    logic [1:0] bresp [2];
    logic [1:0] rresp [2];
    logic [31:0] rdata [2];
    logic [7:0] cfg_a [2];
    logic [15:0] cfg_d [2];
    for (genvar i = 0; i < 2; i++) begin : g_dut
        thresholding_axilite_cfg #(.CFG_ADDR_BITS(8), .K(16), .SIGNED(i == 0)) u_dut (
            .clk(clk), .rst(rst),
            .s_awvalid(s_awvalid), .s_awready(awready[i]), .s_awaddr(s_awaddr),
            .s_wvalid(s_wvalid), .s_wready(wready[i]), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
            .s_bvalid(bvalid[i]), .s_bready(s_bready), .s_bresp(bresp[i]),
            .s_arvalid(s_arvalid), .s_arready(arready[i]), .s_araddr(s_araddr),
            .s_rvalid(rvalid[i]), .s_rready(s_rready), .s_rdata(rdata[i]), .s_rresp(rresp[i]),
            .cfg_en(cfg_en[i]), .cfg_we(cfg_we[i]), .cfg_a(cfg_a[i]), .cfg_d(cfg_d[i]),
            .cfg_rack(cfg_rack), .cfg_q(cfg_q)
        );
    end
    int total = 0, bad = 0;
    int rack_lat = 5;
    logic [15:0] core_q = 0;
    op_t exp_ops [$];
    bit busy = 0, issue_due = 0, b_pend = 0, rd_wait = 0, r_pend = 0, prev_rst = 0;
    logic [15:0] r_q = 0;
    logic [7:0] last_a = 0;
    logic [15:0] last_d = 0;
    logic last_we = 0;
    logic [31:0] last_rdata [2];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    function automatic logic [31:0] ext(input logic [15:0] q, input bit sg);
        return sg ? {{16{q[15]}}, q} : {16'h0000, q};
    endfunction
    task automatic push_op(input logic we, input logic [7:0] a, input logic [15:0] d);
        op_t o;
        o.we = we;
        o.a  = a;
        o.d  = d;
        exp_ops.push_back(o);
    endtask
    // Transaction-level model: an op is due on cfg_en the cycle after its handshake, B follows a
    // write issue directly, R follows the cycle after the core's rack; reset discards everything.
    always @(negedge clk) begin
        op_t cur;
        bit hs;
        if (rst) begin
            busy = 0; issue_due = 0; b_pend = 0; rd_wait = 0; r_pend = 0;
        end else begin
            cur = '0;
            for (int i = 0; i < 2; i++) begin
                if (prev_rst) begin
                    chk("rst_ctrl", {awready[i], wready[i], arready[i], bvalid[i], rvalid[i], cfg_en[i], cfg_we[i]}, 0);
                    chk("rst_cfg_a", cfg_a[i], 0);
                    chk("rst_cfg_d", cfg_d[i], 0);
                    chk("rst_rdata", rdata[i], 0);
                end
                if (awready[i] || wready[i])
                    chk("wr_grant", {awready[i], wready[i], busy, s_awvalid & s_wvalid}, 4'b1101);
                if (arready[i])
                    chk("rd_grant", {arready[i], awready[i], busy, s_arvalid}, 4'b1001);
                chk("cfg_en", cfg_en[i], issue_due);
                chk("bvalid", bvalid[i], b_pend);
                chk("rvalid", rvalid[i], r_pend);
                if (b_pend) chk("bresp", bresp[i], 0);
                if (r_pend) begin
                    chk("rdata", rdata[i], ext(r_q, i == 0));
                    chk("rresp", rresp[i], 0);
                    last_rdata[i] = rdata[i];
                end
            end
            if (issue_due) begin
                chk("op_expected", 32'(exp_ops.size() > 0), 1);
                if (exp_ops.size() > 0) begin
                    cur = exp_ops.pop_front();
                    for (int i = 0; i < 2; i++) begin
                        chk("cfg_we", cfg_we[i], cur.we);
                        chk("cfg_a", cfg_a[i], cur.a);
                        if (cur.we) chk("cfg_d", cfg_d[i], cur.d);
                    end
                    last_a = cfg_a[0];
                    last_d = cfg_d[0];
                    last_we = cfg_we[0];
                end
            end
            hs = (awready[0] & s_awvalid & s_wvalid) | (arready[0] & s_arvalid);
            if (b_pend && s_bready) begin b_pend = 0; busy = 0; end
            if (r_pend && s_rready) begin r_pend = 0; busy = 0; end
            if (rd_wait && cfg_rack) begin rd_wait = 0; r_pend = 1; r_q = cfg_q; end
            if (issue_due) begin
                if (cur.we) b_pend = 1;
                else rd_wait = 1;
            end
            issue_due = hs;
            if (hs) busy = 1;
        end
        prev_rst = rst;
    end
    // Core stand-in: answers a readback rack_lat cycles after its cfg_en
    initial forever begin
        @(negedge clk);
        if (!rst && cfg_en[0] && !cfg_we[0]) begin
            repeat (rack_lat) @(posedge clk);
            #1 cfg_rack = 1; cfg_q = core_q;
            @(posedge clk);
            #1 cfg_rack = 0;
        end
    end
    task automatic wait_hs(input bit wr);
        int n = 0;
        while (n < 200) begin
            @(negedge clk);
            if (wr ? (awready[0] && wready[0]) : arready[0]) break;
            n++;
        end
        if (n >= 200) chk(wr ? "wr_hs_timeout" : "rd_hs_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask
    task automatic do_write(input logic [9:0] addr, input logic [31:0] data, input int aw_delay);
        s_wvalid = 1; s_wdata = data; s_wstrb = 4'hF;
        repeat (aw_delay) begin @(posedge clk); #1; end
        s_awvalid = 1; s_awaddr = addr;
        wait_hs(1);
        s_awvalid = 0; s_wvalid = 0;
    endtask
    task automatic do_read(input logic [9:0] addr);
        s_arvalid = 1; s_araddr = addr;
        wait_hs(0);
        s_arvalid = 0;
    endtask
    task automatic wait_idle();
        int n = 0;
        while ((busy || issue_due) && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) chk("idle_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask
    task automatic pulse_rst();
        rst = 1;
        @(posedge clk);
        #1 rst = 0;
    endtask
    initial begin
        last_rdata[0] = 0; last_rdata[1] = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        push_op(1, 8'h02, 16'h1234);
        do_write(10'h008, 32'h0000_1234, 0);
        wait_idle();
        chk("lit_wr_a", last_a, 8'h02);
        chk("lit_wr_d", last_d, 16'h1234);
        chk("lit_wr_we", last_we, 1);
        core_q = 16'h8001; rack_lat = 5;
        push_op(0, 8'h02, 16'h0);
        do_read(10'h008);
        wait_idle();
        chk("lit_rd_signed", last_rdata[0], 32'hFFFF_8001);
        chk("lit_rd_unsigned", last_rdata[1], 32'h0000_8001);
        pulse_rst();
        core_q = 16'h0123; rack_lat = 2;
        push_op(1, 8'h04, 16'h00AA);
        push_op(0, 8'h05, 16'h0);
        push_op(1, 8'h06, 16'hBEEF);
        push_op(0, 8'h07, 16'h0);
        fork
            begin do_write(10'h010, 32'h0000_00AA, 0); do_write(10'h018, 32'hDEAD_BEEF, 0); end
            begin do_read(10'h014); do_read(10'h01C); end
        join
        wait_idle();
        chk("lit_rr_last_a", last_a, 8'h07);
        chk("lit_rr_rdata", last_rdata[0], 32'h0000_0123);
        s_bready = 0; core_q = 16'hFFFF; rack_lat = 1;
        push_op(1, 8'h08, 16'h0055);
        push_op(0, 8'h09, 16'h0);
        do_write(10'h020, 32'h0000_0055, 0);
        fork
            begin repeat (10) begin @(posedge clk); #1; end s_bready = 1; end
            do_read(10'h024);
        join
        wait_idle();
        chk("lit_ff_signed", last_rdata[0], 32'hFFFF_FFFF);
        chk("lit_ff_unsigned", last_rdata[1], 32'h0000_FFFF);
        push_op(1, 8'h0B, 16'h0F0F);
        do_write(10'h02C, 32'h0000_0F0F, 7);
        wait_idle();
        chk("lit_late_aw_a", last_a, 8'h0B);
        push_op(1, 8'hFF, 16'h5678);
        do_write(10'h3FF, 32'h1234_5678, 0);
        wait_idle();
        chk("lit_top_d", last_d, 16'h5678);
        core_q = 16'h4444; rack_lat = 6;
        push_op(0, 8'h0C, 16'h0);
        do_read(10'h030);
        repeat (3) begin @(posedge clk); #1; end
        pulse_rst();
        repeat (8) begin @(posedge clk); #1; end
        core_q = 16'h7FFE; rack_lat = 5;
        push_op(0, 8'h0D, 16'h0);
        do_read(10'h034);
        wait_idle();
        chk("lit_after_abort_s", last_rdata[0], 32'h0000_7FFE);
        chk("lit_after_abort_u", last_rdata[1], 32'h0000_7FFE);
        chk("ops_left", exp_ops.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end
endmodule
